// File: rtl/pipe_pkg.sv
// Shared opcode classes, instruction-field helpers and FSM states for the
// four-stage pipeline sequencer.
package pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_WAIT,
    S_READY,
    S_HALT
  } state_t;

  function automatic logic [3:0] op_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  // Ops 2 and 6..14 carry an immediate in [7:4] instead of rb
  function automatic logic imm_b_op(input logic [3:0] op);
    return (op == 4'h2) || ((op >= 4'h6) && (op <= 4'hE));
  endfunction

  function automatic logic writes_reg(input logic [15:0] instr);
    return (op_of(instr) != OP_NOP) && (op_of(instr) != OP_HALT);
  endfunction

  function automatic logic reads_ra(input logic [15:0] instr);
    return (op_of(instr) != OP_NOP) && (op_of(instr) != OP_HALT);
  endfunction

  function automatic logic reads_rb(input logic [15:0] instr);
    return reads_ra(instr) && !imm_b_op(op_of(instr));
  endfunction

  function automatic logic is_halt(input logic [15:0] instr);
    return op_of(instr) == OP_HALT;
  endfunction

endpackage

// File: rtl/pipe_sequencer_hazard_unit.sv
// Read-after-write hazard detection: the decode-stage instruction reads a
// register still pending a write from execute or writeback. No forwarding.
module hazard_unit
  import pipe_pkg::*;
(
  input  logic [15:0] ird,
  input  logic [15:0] ire,
  input  logic [15:0] irw,
  output logic        haz
);

  logic [3:0] ra;
  logic [3:0] rb;
  logic       ra_hit;
  logic       rb_hit;

  // Compare decode source fields against pending destinations
  always_comb begin
    ra     = ird[3:0];
    rb     = ird[7:4];
    ra_hit = (writes_reg(ire) && (ire[11:8] == ra)) ||
             (writes_reg(irw) && (irw[11:8] == ra));
    rb_hit = (writes_reg(ire) && (ire[11:8] == rb)) ||
             (writes_reg(irw) && (irw[11:8] == rb));
    haz    = (reads_ra(ird) && ra_hit) || (reads_rb(ird) && rb_hit);
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Sequencing controller for the 16-bit four-stage DE2 CPU: program counter,
// stage instruction registers, hazard stalls, HALT drain and run/step control.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            tick,
  input  logic            step,
  input  logic [IW-1:0]   instr_in,
  output logic [PC_W-1:0] mem_addr,
  output logic [IW-1:0]   irf,
  output logic [IW-1:0]   ird,
  output logic [IW-1:0]   ire,
  output logic [IW-1:0]   irw,
  output logic            adv,
  output logic            op_latch,
  output logic            wb_we,
  output logic            stall,
  output logic            halted,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     stall_cnt
);

  state_t          state_q;
  state_t          state_d;
  logic            wait_q;
  logic            step_q;
  logic            fetch_stop;
  logic [PC_W-1:0] pc;
  logic            req;
  logic            do_adv;
  logic            haz;

  hazard_unit u_hazard (
    .ird (ird),
    .ire (ire),
    .irw (irw),
    .haz (haz)
  );

  assign mem_addr = pc;

  // State register, two-cycle memory-latency counter and step edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      wait_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_q == S_WAIT) && !wait_q;
      step_q  <= step;
    end
  end

  // Next-state: only S_READY accepts requests; the rest are dropped
  always_comb begin
    req     = (run & tick) | (step & ~step_q);
    do_adv  = (state_q == S_READY) && req;
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (wait_q) state_d = S_READY;
      S_READY: begin
        if (do_adv) begin
          // Stalled and fetch-stopped advances leave pc unchanged, so the
          // memory output is still valid and no latency wait is needed.
          if (is_halt(ire))            state_d = S_HALT;
          else if (haz || fetch_stop)  state_d = S_READY;
          else                         state_d = S_WAIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  // Datapath strobes, valid in the cycle before the updating edge
  always_comb begin
    adv      = do_adv;
    stall    = do_adv & haz;
    op_latch = do_adv & ~haz;
    wb_we    = do_adv & writes_reg(irw);
    halted   = (state_q == S_HALT);
  end

  // Pipeline registers, program counter, fetch-stop flag and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      irf        <= '0;
      ird        <= '0;
      ire        <= '0;
      irw        <= '0;
      fetch_stop <= 1'b0;
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
    end else if (do_adv) begin
      irw       <= ire;
      cycle_cnt <= cycle_cnt + 16'd1;
      if (haz) begin
        ire       <= '0;
        stall_cnt <= stall_cnt + 16'd1;
      end else begin
        ire <= ird;
        if (fetch_stop) begin
          ird <= '0;
        end else begin
          ird <= irf;
          irf <= instr_in;
          pc  <= pc + PC_W'(1);
          if (is_halt(irf)) fetch_stop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Sequencing controller for the 16-bit, four-stage (fetch/decode/execute/writeback) CPU on the DE2 board. It owns the program counter, the fetch/decode/execute/writeback instruction registers, read-after-write hazard stalls, HALT handling, and run/single-step control. It drives the instruction-memory address and the strobes that tell the register file and ALU datapath when to latch operands and write results.

## Interface
Parameters:
- PC_W, 10, program counter / instruction-memory address width
- IW, 16, instruction width; fields: op[15:12], rc(dest)[11:8], rb/imm[7:4], ra[3:0]

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; free-run mode, advances on each tick
- tick  in  1  one-cycle pulse from the clock divider; advance rate in run mode
- step  in  1  debounced key level; each rising edge requests one advance
- instr_in  in  16  instruction-memory q; valid the 2nd cycle after mem_addr changes
- mem_addr  out  10  = pc
- irf, ird, ire, irw  out  16 each  stage instruction registers
- adv  out  1  one-cycle pulse on every accepted advance, including stalls
- op_latch  out  1  pulse with adv when ird moves to ire; datapath latches regs[ra], regs[rb]/imm
- wb_we  out  1  pulse with adv when pre-advance irw writes a register; dest = irw[11:8]
- stall  out  1  pulse with adv when a bubble is inserted
- halted  out  1  level; HALT retired
- cycle_cnt  out  16  accepted advances, wraps at 0xFFFF
- stall_cnt  out  16  inserted bubbles, wraps

## Operation
Opcode classes:
- NOP = 0x0. HALT = 0xF.
- Writes a register: op is not 0x0 and not 0xF.
- Reads ra: op is not 0x0 and not 0xF.
- Reads rb: additionally op is not 2 and op is below 6. Ops 2 and 6..14 use [7:4] as an immediate.

Requests:
- step_rise = step & ~step_q.
- req = (run & tick) | step_rise. Coincident sources give exactly one advance.

FSM:
- S_WAIT: wait for memory read latency. Go to S_READY after 2 cycles (memory is registered on both address and output).
- S_READY: if req, perform an advance.
  - Normal advance: go to S_WAIT.
  - Stalled advance or fetch-stopped advance: stay in S_READY.
  - Retiring HALT: go to S_HALT.
- S_HALT: absorb all requests; leave only via rst_n.
- Requests arriving outside S_READY are dropped, not queued.

Hazard:
- haz = ird reads ra or rb, and that register equals the dest of ire or irw, and that instruction writes a register.
- The register file does not forward a same-edge write.

Normal advance (no hazard):
- irw←ire, ire←ird, ird←irf, irf←instr_in, pc←pc+1 (1023 wraps to 0).
- op_latch=1. wb_we = writes(irw_old).

Stalled advance:
- irw←ire, ire←0x0000, stall=1.
- irf, ird and pc hold. op_latch=0.

HALT:
- When HALT moves into ird, set fetch_stop.
- While fetch_stop is set: pc and irf hold, and ird←0x0000 on each advance. Execute and writeback continue to drain.
- When HALT moves into irw, go to S_HALT and set halted=1.
- HALT is never hazard-stalled; it reads no registers.

Counters:
- cycle_cnt increments on every adv.
- stall_cnt increments on every stall.

Reset:
- Values: pc=0; irf/ird/ire/irw=0; all pulses 0; halted=0; counters=0; fetch_stop=0; step_q=0.
- State after reset: S_WAIT.
- Reset asserted mid-stall or mid-HALT-drain clears everything immediately (asynchronous).

## Timing
- First instruction (pc=0) is captured into irf on the first advance at least 2 cycles after rst_n deasserts.
- Pulses adv/op_latch/wb_we/stall coincide with the clock edge at which the registers update. The datapath samples pre-edge irw/ird.
- Minimum advance spacing: 3 cycles (normal); 1 cycle when stalled or fetch-stopped.
- Dependent back-to-back instructions: 2 bubbles (dependent on ire) or 1 bubble (dependent on irw only).

## Structure
- Package pipe_pkg:
  - opcode constants OP_NOP, OP_HALT, immediate-B opcode predicate.
  - Functions writes_reg(), reads_ra(), reads_rb().
  - FSM state enum.
- Sub-module hazard_unit (combinational): inputs ird, ire, irw; output haz. Reused by a future forwarding unit.

## Test plan
- Reset, ROM {0x1312, 0x0000, 0x0000, 0xF000}, run=1 with tick every 4 cycles → pc 0,1,2,3. HALT in irw after 7 advances. halted=1, cycle_cnt=7, stall_cnt=0.
- ROM {0x1312, 0x1433}: r3 is written by word 0 and read as ra by word 1 → 2 bubbles. stall_cnt=2. op_latch for word 1 only after 0x1312 leaves irw.
- ROM {0x2312, 0x1453}: word 1 reads r3 via ra → 2 bubbles. ROM {0x2312, 0x2534}: word 1's [7:4] is an immediate, not a register read → stall_cnt=0.
- run=0, step rising edges 1 cycle apart → only edges landing in S_READY advance. Holding step high → exactly one advance. run&tick coinciding with step_rise → cycle_cnt +1.
- Assert rst_n low during a stall with pc=5 → all IRs 0, pc=0, counters 0 in the same cycle. Resume from pc=0.
- pc preset to 1023 by executing NOPs → next advance gives pc=0. cycle_cnt wraps 0xFFFF→0x0000.
